register_file_sb: RTL and testbench

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb.sv | 91 +++++++++
 tb/tb_register_file_sb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// Register file with combinational reads and a per-register pending scoreboard.
// Optional write-to-read bypass enabled by defining REGISTER_FILE_BYPASS_EN.
module register_file_sb #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Reg_Write_i,
    input  logic [ADDR_W-1:0] Write_Register_i,
    input  logic [WIDTH-1:0]  Write_Data_i,
    input  logic [ADDR_W-1:0] Read_Register_1_i,
    input  logic [ADDR_W-1:0] Read_Register_2_i,
    output logic [WIDTH-1:0]  Read_Data_1_o,
    output logic [WIDTH-1:0]  Read_Data_2_o,
    input  logic              Issue_i,
    input  logic [ADDR_W-1:0] Issue_Register_i,
    output logic              Busy_1_o,
    output logic              Busy_2_o,
    output logic              Stall_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    logic wr_en;
    logic iss_en;

    assign wr_en  = Reg_Write_i && (Write_Register_i != '0);
    assign iss_en = Issue_i && (Issue_Register_i != '0);

    // Issue is applied after the write clear so a newer producer keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[Write_Register_i] = 1'b0;
        end
        if (iss_en) begin
            pending_d[Issue_Register_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[Write_Register_i] <= Write_Data_i;
            end
            pending_q <= pending_d;
        end
    end

    logic [WIDTH-1:0] stored_1;
    logic [WIDTH-1:0] stored_2;
    logic             pend_1;
    logic             pend_2;

    assign stored_1 = (Read_Register_1_i == '0) ? '0 : mem_q[Read_Register_1_i];
    assign stored_2 = (Read_Register_2_i == '0) ? '0 : mem_q[Read_Register_2_i];
    assign pend_1   = (Read_Register_1_i == '0) ? 1'b0 : pending_q[Read_Register_1_i];
    assign pend_2   = (Read_Register_2_i == '0) ? 1'b0 : pending_q[Read_Register_2_i];

`ifdef REGISTER_FILE_BYPASS_EN
    logic hit_1;
    logic hit_2;

    assign hit_1 = wr_en && (Read_Register_1_i == Write_Register_i);
    assign hit_2 = wr_en && (Read_Register_2_i == Write_Register_i);

    assign Read_Data_1_o = hit_1 ? Write_Data_i : stored_1;
    assign Read_Data_2_o = hit_2 ? Write_Data_i : stored_2;
    assign Busy_1_o      = pend_1 && !hit_1;
    assign Busy_2_o      = pend_2 && !hit_2;
`else
    assign Read_Data_1_o = stored_1;
    assign Read_Data_2_o = stored_2;
    assign Busy_1_o      = pend_1;
    assign Busy_2_o      = pend_2;
`endif

    assign Stall_o = Busy_1_o || Busy_2_o;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb (both bypass builds).
module tb_register_file_sb;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              reset;
    logic              Reg_Write_i;
    logic [ADDR_W-1:0] Write_Register_i;
    logic [WIDTH-1:0]  Write_Data_i;
    logic [ADDR_W-1:0] Read_Register_1_i;
    logic [ADDR_W-1:0] Read_Register_2_i;
    logic [WIDTH-1:0]  Read_Data_1_o;
    logic [WIDTH-1:0]  Read_Data_2_o;
    logic              Issue_i;
    logic [ADDR_W-1:0] Issue_Register_i;
    logic              Busy_1_o;
    logic              Busy_2_o;
    logic              Stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .Reg_Write_i      (Reg_Write_i),
        .Write_Register_i (Write_Register_i),
        .Write_Data_i     (Write_Data_i),
        .Read_Register_1_i(Read_Register_1_i),
        .Read_Register_2_i(Read_Register_2_i),
        .Read_Data_1_o    (Read_Data_1_o),
        .Read_Data_2_o    (Read_Data_2_o),
        .Issue_i          (Issue_i),
        .Issue_Register_i (Issue_Register_i),
        .Busy_1_o         (Busy_1_o),
        .Busy_2_o         (Busy_2_o),
        .Stall_o          (Stall_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic test_reset();
        reset = 1'b1;
        Reg_Write_i = 1'b0; Write_Register_i = '0; Write_Data_i = '0;
        Issue_i = 1'b0; Issue_Register_i = '0;
        Read_Register_1_i = '0; Read_Register_2_i = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        Read_Register_1_i = 5'd0; Read_Register_2_i = 5'd31;
        #1;
        n_checks++; if (Read_Data_1_o !== 32'h0) begin n_fail++; $display("FAIL rst_data1: got %h expected %h", Read_Data_1_o, 32'h0); end
        n_checks++; if (Read_Data_2_o !== 32'h0) begin n_fail++; $display("FAIL rst_data2: got %h expected %h", Read_Data_2_o, 32'h0); end
        n_checks++; if (Busy_1_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy1: got %b expected 0", Busy_1_o); end
        n_checks++; if (Busy_2_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy2: got %b expected 0", Busy_2_o); end
        n_checks++; if (Stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", Stall_o); end
    endtask

    task automatic test_write_read();
        @(negedge clock);
        Reg_Write_i = 1'b1; Write_Register_i = 5'd5; Write_Data_i = 32'hDEADBEEF;
        Read_Register_1_i = 5'd5; Read_Register_2_i = 5'd5;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        n_checks++; if (Read_Data_1_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr5_same_cycle: got %h expected %h", Read_Data_1_o, 32'hDEADBEEF); end
`else
        n_checks++; if (Read_Data_1_o !== 32'h0) begin n_fail++; $display("FAIL wr5_same_cycle: got %h expected %h", Read_Data_1_o, 32'h0); end
`endif
        @(negedge clock);
        Write_Register_i = 5'd6; Write_Data_i = 32'h0000_1111;
        #1;
        n_checks++; if (Read_Data_1_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr5_rd1: got %h expected %h", Read_Data_1_o, 32'hDEADBEEF); end
        n_checks++; if (Read_Data_2_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr5_rd2: got %h expected %h", Read_Data_2_o, 32'hDEADBEEF); end
        n_checks++; if (Busy_1_o !== 1'b0) begin n_fail++; $display("FAIL wr5_busy1: got %b expected 0", Busy_1_o); end
        @(negedge clock);
        Reg_Write_i = 1'b0;
        Read_Register_1_i = 5'd6; Read_Register_2_i = 5'd5;
        #1;
        n_checks++; if (Read_Data_1_o !== 32'h0000_1111) begin n_fail++; $display("FAIL b2b_rd6: got %h expected %h", Read_Data_1_o, 32'h0000_1111); end
        n_checks++; if (Read_Data_2_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rd5: got %h expected %h", Read_Data_2_o, 32'hDEADBEEF); end
    endtask

    task automatic test_reg_zero();
        @(negedge clock);
        Reg_Write_i = 1'b1; Write_Register_i = 5'd0; Write_Data_i = 32'h1234;
        Read_Register_1_i = 5'd0; Read_Register_2_i = 5'd0;
        #1;
        n_checks++; if (Read_Data_2_o !== 32'h0) begin n_fail++; $display("FAIL r0_same_cycle: got %h expected %h", Read_Data_2_o, 32'h0); end
        @(negedge clock);
        Reg_Write_i = 1'b0;
        Issue_i = 1'b1; Issue_Register_i = 5'd0;
        #1;
        n_checks++; if (Read_Data_1_o !== 32'h0) begin n_fail++; $display("FAIL r0_data: got %h expected %h", Read_Data_1_o, 32'h0); end
        @(negedge clock);
        Issue_i = 1'b0;
        #1;
        n_checks++; if (Busy_1_o !== 1'b0) begin n_fail++; $display("FAIL r0_busy1: got %b expected 0", Busy_1_o); end
        n_checks++; if (Stall_o !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b expected 0", Stall_o); end
    endtask

    task automatic test_issue_bypass();
        @(negedge clock);
        Issue_i = 1'b1; Issue_Register_i = 5'd7;
        Read_Register_1_i = 5'd7; Read_Register_2_i = 5'd0;
        @(negedge clock);
        Issue_i = 1'b0;
        #1;
        n_checks++; if (Busy_1_o !== 1'b1) begin n_fail++; $display("FAIL iss7_busy1: got %b expected 1", Busy_1_o); end
        n_checks++; if (Stall_o !== 1'b1) begin n_fail++; $display("FAIL iss7_stall: got %b expected 1", Stall_o); end
        n_checks++; if (Busy_2_o !== 1'b0) begin n_fail++; $display("FAIL iss7_busy2: got %b expected 0", Busy_2_o); end
        Reg_Write_i = 1'b1; Write_Register_i = 5'd7; Write_Data_i = 32'hA5;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        n_checks++; if (Read_Data_1_o !== 32'hA5) begin n_fail++; $display("FAIL byp7_data: got %h expected %h", Read_Data_1_o, 32'hA5); end
        n_checks++; if (Busy_1_o !== 1'b0) begin n_fail++; $display("FAIL byp7_busy: got %b expected 0", Busy_1_o); end
        n_checks++; if (Stall_o !== 1'b0) begin n_fail++; $display("FAIL byp7_stall: got %b expected 0", Stall_o); end
`else
        n_checks++; if (Read_Data_1_o !== 32'h0) begin n_fail++; $display("FAIL byp7_data: got %h expected %h", Read_Data_1_o, 32'h0); end
        n_checks++; if (Busy_1_o !== 1'b1) begin n_fail++; $display("FAIL byp7_busy: got %b expected 1", Busy_1_o); end
        n_checks++; if (Stall_o !== 1'b1) begin n_fail++; $display("FAIL byp7_stall: got %b expected 1", Stall_o); end
`endif
        @(negedge clock);
        Reg_Write_i = 1'b0;
        #1;
        n_checks++; if (Read_Data_1_o !== 32'hA5) begin n_fail++; $display("FAIL wr7_data: got %h expected %h", Read_Data_1_o, 32'hA5); end
        n_checks++; if (Busy_1_o !== 1'b0) begin n_fail++; $display("FAIL wr7_busy: got %b expected 0", Busy_1_o); end
        n_checks++; if (Stall_o !== 1'b0) begin n_fail++; $display("FAIL wr7_stall: got %b expected 0", Stall_o); end
    endtask

    task automatic test_issue_write_same();
        @(negedge clock);
        Issue_i = 1'b1; Issue_Register_i = 5'd9;
        Reg_Write_i = 1'b1; Write_Register_i = 5'd9; Write_Data_i = 32'h55;
        Read_Register_1_i = 5'd9; Read_Register_2_i = 5'd9;
        @(negedge clock);
        Issue_i = 1'b0; Reg_Write_i = 1'b0;
        #1;
        n_checks++; if (Read_Data_1_o !== 32'h55) begin n_fail++; $display("FAIL iw9_data1: got %h expected %h", Read_Data_1_o, 32'h55); end
        n_checks++; if (Read_Data_2_o !== 32'h55) begin n_fail++; $display("FAIL iw9_data2: got %h expected %h", Read_Data_2_o, 32'h55); end
        n_checks++; if (Busy_1_o !== 1'b1) begin n_fail++; $display("FAIL iw9_busy1: got %b expected 1", Busy_1_o); end
        n_checks++; if (Busy_2_o !== 1'b1) begin n_fail++; $display("FAIL iw9_busy2: got %b expected 1", Busy_2_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        Issue_i = 1'b1; Issue_Register_i = 5'd3;
        Read_Register_1_i = 5'd3; Read_Register_2_i = 5'd4;
        @(negedge clock);
        #1;
        n_checks++; if (Busy_1_o !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy3: got %b expected 1", Busy_1_o); end
        reset = 1'b1;
        Issue_i = 1'b1; Issue_Register_i = 5'd4;
        Reg_Write_i = 1'b1; Write_Register_i = 5'd3; Write_Data_i = 32'hFF;
        @(negedge clock);
        reset = 1'b0; Issue_i = 1'b0; Reg_Write_i = 1'b0;
        #1;
        n_checks++; if (Read_Data_1_o !== 32'h0) begin n_fail++; $display("FAIL rst3_data: got %h expected %h", Read_Data_1_o, 32'h0); end
        n_checks++; if (Busy_1_o !== 1'b0) begin n_fail++; $display("FAIL rst3_busy: got %b expected 0", Busy_1_o); end
        n_checks++; if (Busy_2_o !== 1'b0) begin n_fail++; $display("FAIL rst4_busy: got %b expected 0", Busy_2_o); end
        n_checks++; if (Stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b expected 0", Stall_o); end
        Read_Register_1_i = 5'd5; Read_Register_2_i = 5'd9;
        #1;
        n_checks++; if (Read_Data_1_o !== 32'h0) begin n_fail++; $display("FAIL rst5_data: got %h expected %h", Read_Data_1_o, 32'h0); end
        n_checks++; if (Read_Data_2_o !== 32'h0) begin n_fail++; $display("FAIL rst9_data: got %h expected %h", Read_Data_2_o, 32'h0); end
        n_checks++; if (Busy_2_o !== 1'b0) begin n_fail++; $display("FAIL rst9_busy: got %b expected 0", Busy_2_o); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg_zero();
        test_issue_bypass();
        test_issue_write_same();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
